// File: rtl/cv32e40x_xif_issuer.sv
// Core-side eXtension-interface initiator: issues one offloaded instruction at a time,
// commits or kills it, and writes the returned result into the register file.
module cv32e40x_xif_issuer #(
  parameter int unsigned X_NUM_RS    = 2,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  // pipeline side
  input  logic                            off_valid_i,
  output logic                            off_ready_o,
  input  logic [31:0]                     off_instr_i,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] off_rs_i,
  input  logic [X_NUM_RS-1:0]             off_rs_valid_i,
  input  logic                            off_kill_i,
  output logic                            off_done_o,
  output logic                            off_illegal_o,
  output logic                            busy_o,
  // issue channel
  output logic                            issue_valid_o,
  input  logic                            issue_ready_i,
  output logic [31:0]                     issue_instr_o,
  output logic [X_ID_WIDTH-1:0]           issue_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_o,
  output logic [X_NUM_RS-1:0]             issue_rs_valid_o,
  input  logic                            issue_accept_i,
  input  logic                            issue_writeback_i,
  // commit channel
  output logic                            commit_valid_o,
  output logic [X_ID_WIDTH-1:0]           commit_id_o,
  output logic                            commit_kill_o,
  // result channel
  input  logic                            result_valid_i,
  output logic                            result_ready_o,
  input  logic [X_ID_WIDTH-1:0]           result_id_i,
  input  logic [4:0]                      result_rd_i,
  input  logic [X_RFW_WIDTH-1:0]          result_data_i,
  input  logic                            result_we_i,
  input  logic                            result_exc_i,
  // register-file write port
  output logic                            rf_we_o,
  output logic [4:0]                      rf_waddr_o,
  output logic [X_RFW_WIDTH-1:0]          rf_wdata_o,
  output logic                            xif_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, RESULT} state_e;

  state_e                            state_q;
  logic [X_ID_WIDTH-1:0]             id_q;
  logic [X_ID_WIDTH-1:0]             id_d;
  logic                              kill_pending_q;
  logic [31:0]                       instr_q;
  logic [X_NUM_RS*X_RFR_WIDTH-1:0]   rs_q;
  logic [X_NUM_RS-1:0]               rs_valid_q;
  logic                              accept_q;
  logic                              writeback_q;
  logic                              rf_we_q;
  logic [4:0]                        rf_waddr_q;
  logic [X_RFW_WIDTH-1:0]            rf_wdata_q;
  logic                              done_q;
  logic                              illegal_q;
  logic                              xif_err_q;
  logic                              commit_kill;
  logic                              result_hit;

  assign id_d        = id_q + 1'b1;
  // A late flush arriving during the commit beat still kills the transaction.
  assign commit_kill = !accept_q || kill_pending_q || off_kill_i;
  assign result_hit  = result_valid_i && (result_id_i == id_q);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      id_q           <= '0;
      kill_pending_q <= 1'b0;
      instr_q        <= '0;
      rs_q           <= '0;
      rs_valid_q     <= '0;
      accept_q       <= 1'b0;
      writeback_q    <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      xif_err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge
      // values; pulses default low here and are overridden below for one cycle.
      rf_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      xif_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (off_valid_i && !off_kill_i) begin
            instr_q    <= off_instr_i;
            rs_q       <= off_rs_i;
            rs_valid_q <= off_rs_valid_i;
            state_q    <= ISSUE;
          end
        end

        ISSUE: begin
          if (off_kill_i) kill_pending_q <= 1'b1;
          if (issue_ready_i) begin
            accept_q    <= issue_accept_i;
            writeback_q <= issue_writeback_i;
            state_q     <= COMMIT;
          end
        end

        COMMIT: begin
          if (commit_kill) begin
            illegal_q      <= !accept_q && !kill_pending_q && !off_kill_i;
            id_q           <= id_d;
            kill_pending_q <= 1'b0;
            state_q        <= IDLE;
          end else begin
            state_q <= RESULT;
          end
        end

        RESULT: begin
          if (result_hit) begin
            rf_we_q        <= result_we_i && writeback_q && !result_exc_i &&
                              (result_rd_i != 5'd0);
            rf_waddr_q     <= result_rd_i;
            rf_wdata_q     <= result_data_i;
            done_q         <= 1'b1;
            id_q           <= id_d;
            kill_pending_q <= 1'b0;
            state_q        <= IDLE;
          end else if (result_valid_i) begin
            xif_err_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign off_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign issue_valid_o    = (state_q == ISSUE);
  assign issue_instr_o    = instr_q;
  assign issue_id_o       = id_q;
  assign issue_rs_o       = rs_q;
  assign issue_rs_valid_o = rs_valid_q;
  assign commit_valid_o   = (state_q == COMMIT);
  assign commit_id_o      = id_q;
  assign commit_kill_o    = (state_q == COMMIT) && commit_kill;
  assign result_ready_o   = (state_q == RESULT);
  assign rf_we_o          = rf_we_q;
  assign rf_waddr_o       = rf_waddr_q;
  assign rf_wdata_o       = rf_wdata_q;
  assign off_done_o       = done_q;
  assign off_illegal_o    = illegal_q;
  assign xif_err_o        = xif_err_q;

endmodule
